// File: rtl/scarv_cop_palu_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : scarv_cop_palu_issue_pkg                               |
// | Description : Shared coprocessor definitions for the packed-ALU      |
// |               issue stage: FSM encoding, timeout default,            |
// |               instruction class / subclass codes.                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package scarv_cop_palu_issue_pkg;

  // Issue FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_t;

  // Maximum number of cycles an instruction may stay in EXEC.
  localparam int TIMEOUT_CYCLES_DEFAULT = 64;

  // Field types.
  typedef logic [3:0]  cpr_idx_t;
  typedef logic [3:0]  ben_t;
  typedef logic [31:0] word_t;

  // Instruction class codes.
  localparam logic [3:0] CLASS_PACKED_ARITH = 4'd1;
  localparam logic [3:0] CLASS_MOVE         = 4'd2;

  // Packed-arithmetic subclass codes.
  localparam logic [4:0] SUBCLASS_PADD   = 5'd1;
  localparam logic [4:0] SUBCLASS_PSUB   = 5'd2;
  localparam logic [4:0] SUBCLASS_PMUL   = 5'd3;
  localparam logic [4:0] SUBCLASS_CMOV_T = 5'd8;
  localparam logic [4:0] SUBCLASS_CMOV_F = 5'd9;

  // Pack width codes.
  localparam logic [2:0] PW_32 = 3'd0;
  localparam logic [2:0] PW_16 = 3'd1;
  localparam logic [2:0] PW_8  = 3'd2;

endpackage
`default_nettype wire

// File: rtl/scarv_cop_palu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : scarv_cop_palu_issue_if                                |
// | Description : Decoded-instruction handshake bundle between the       |
// |               decoder (master) and the packed-ALU issue stage        |
// |               (slave).                                               |
// |   id_valid/id_ready : transfer when both high                        |
// |   id_class, id_subclass, id_pw, id_imm : instruction fields          |
// |   id_crs1..3, id_crd : CPR indices; id_gpr_rs1 : GPR operand         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface scarv_cop_palu_issue_if;
  import scarv_cop_palu_issue_pkg::*;

  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_class;
  logic [4:0]  id_subclass;
  logic [2:0]  id_pw;
  word_t       id_imm;
  cpr_idx_t    id_crs1;
  cpr_idx_t    id_crs2;
  cpr_idx_t    id_crs3;
  cpr_idx_t    id_crd;
  word_t       id_gpr_rs1;

  modport master (
    output id_valid, id_class, id_subclass, id_pw, id_imm,
           id_crs1, id_crs2, id_crs3, id_crd, id_gpr_rs1,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_class, id_subclass, id_pw, id_imm,
           id_crs1, id_crs2, id_crs3, id_crd, id_gpr_rs1,
    output id_ready
  );

endinterface
`default_nettype wire

// File: rtl/scarv_cop_palu_issue_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : scarv_cop_palu_fwd                                     |
// | Description : Byte-lane operand forwarding mux. When enabled and the |
// |               source index matches the writeback destination, each  |
// |               byte whose writeback enable is set is taken from the   |
// |               writeback data; all other bytes come from the RF.      |
// |   fwd_en  : writeback in progress this cycle                         |
// |   rs_idx  : source CPR index;  wb_crd : writeback CPR index          |
// |   wb_ben  : writeback byte enables; wb_data : writeback data         |
// |   rf_data : register-file read data; operand : forwarded operand     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module scarv_cop_palu_fwd
  import scarv_cop_palu_issue_pkg::*;
(
  input  logic     fwd_en,
  input  cpr_idx_t rs_idx,
  input  cpr_idx_t wb_crd,
  input  ben_t     wb_ben,
  input  word_t    wb_data,
  input  word_t    rf_data,
  output word_t    operand
);

  logic w_hit;
  assign w_hit = fwd_en && (rs_idx == wb_crd);

  // A zero byte-enable (e.g. untaken conditional move) forwards nothing.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign operand[8*k +: 8] = (w_hit && wb_ben[k]) ? wb_data[8*k +: 8]
                                                    : rf_data[8*k +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/scarv_cop_palu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : scarv_cop_palu_issue                                   |
// | Description : Issue stage for the packed ALU. Registers a decoded    |
// |               instruction and its (forwarded) CPR operands, holds    |
// |               them on the ALU issue port until done / timeout /      |
// |               flush, then performs a one-cycle CPR writeback.        |
// |   g_clk, g_resetn     : clock, async active-low reset                |
// |   id                  : decoded-instruction handshake (slave)        |
// |   cpr_rsN_addr/rdata  : combinational CPR read ports (N=1..3)        |
// |   palu_*              : issue port to / result from the packed ALU   |
// |   cpr_rd_*            : CPR write port                               |
// |   flush               : abort in-flight instruction                  |
// |   busy, timeout_err   : status outputs                               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module scarv_cop_palu_issue
  import scarv_cop_palu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  scarv_cop_palu_issue_if.slave  id,
  output cpr_idx_t               cpr_rs1_addr,
  input  word_t                  cpr_rs1_rdata,
  output cpr_idx_t               cpr_rs2_addr,
  input  word_t                  cpr_rs2_rdata,
  output cpr_idx_t               cpr_rs3_addr,
  input  word_t                  cpr_rs3_rdata,
  output logic                   palu_ivalid,
  input  logic                   palu_idone,
  output word_t                  palu_gpr_rs1,
  output word_t                  palu_rs1,
  output word_t                  palu_rs2,
  output word_t                  palu_rs3,
  output word_t                  palu_imm,
  output logic [2:0]             palu_pw,
  output logic [3:0]             palu_class,
  output logic [4:0]             palu_subclass,
  input  ben_t                   palu_cpr_rd_ben,
  input  word_t                  palu_cpr_rd_wdata,
  output ben_t                   cpr_rd_ben,
  output cpr_idx_t               cpr_rd_addr,
  output word_t                  cpr_rd_wdata,
  input  logic                   flush,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES - 1);

  issue_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_class;
  logic [4:0]       r_subclass;
  logic [2:0]       r_pw;
  word_t            r_imm;
  word_t            r_gpr_rs1;
  word_t            r_rs1;
  word_t            r_rs2;
  word_t            r_rs3;
  cpr_idx_t         r_crd;
  ben_t             r_wb_ben;
  word_t            r_wb_data;
  logic             r_timeout_err;

  logic  w_transfer;
  logic  w_wb;
  word_t w_op1;
  word_t w_op2;
  word_t w_op3;

  // Read ports follow the decoder directly so operands are ready on transfer.
  assign cpr_rs1_addr = id.id_crs1;
  assign cpr_rs2_addr = id.id_crs2;
  assign cpr_rs3_addr = id.id_crs3;

  // flush blocks acceptance in every state.
  assign id.id_ready  = (r_state != ST_EXEC) && !flush;
  assign w_transfer   = id.id_valid && id.id_ready;
  assign w_wb         = (r_state == ST_WB);

  scarv_cop_palu_fwd u_fwd_rs1 (
    .fwd_en (w_wb), .rs_idx (id.id_crs1), .wb_crd (r_crd),
    .wb_ben (r_wb_ben), .wb_data (r_wb_data),
    .rf_data (cpr_rs1_rdata), .operand (w_op1)
  );

  scarv_cop_palu_fwd u_fwd_rs2 (
    .fwd_en (w_wb), .rs_idx (id.id_crs2), .wb_crd (r_crd),
    .wb_ben (r_wb_ben), .wb_data (r_wb_data),
    .rf_data (cpr_rs2_rdata), .operand (w_op2)
  );

  scarv_cop_palu_fwd u_fwd_rs3 (
    .fwd_en (w_wb), .rs_idx (id.id_crs3), .wb_crd (r_crd),
    .wb_ben (r_wb_ben), .wb_data (r_wb_data),
    .rf_data (cpr_rs3_rdata), .operand (w_op3)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_class       <= '0;
      r_subclass    <= '0;
      r_pw          <= '0;
      r_imm         <= '0;
      r_gpr_rs1     <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rs3         <= '0;
      r_crd         <= '0;
      r_wb_ben      <= '0;
      r_wb_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;

      // Transfer is only possible in IDLE or WB; both enter EXEC.
      if (w_transfer) begin
        r_class    <= id.id_class;
        r_subclass <= id.id_subclass;
        r_pw       <= id.id_pw;
        r_imm      <= id.id_imm;
        r_gpr_rs1  <= id.id_gpr_rs1;
        r_rs1      <= w_op1;
        r_rs2      <= w_op2;
        r_rs3      <= w_op3;
        r_crd      <= id.id_crd;
        r_cnt      <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_transfer) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Priority: flush > done > timeout (done on the last cycle wins).
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (palu_idone) begin
            r_wb_ben  <= palu_cpr_rd_ben;
            r_wb_data <= palu_cpr_rd_wdata;
            r_state   <= ST_WB;
          end else if (r_cnt == c_cnt_max) begin
            r_state       <= ST_IDLE;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          r_state <= w_transfer ? ST_EXEC : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign palu_ivalid   = (r_state == ST_EXEC);
  assign palu_gpr_rs1  = r_gpr_rs1;
  assign palu_rs1      = r_rs1;
  assign palu_rs2      = r_rs2;
  assign palu_rs3      = r_rs3;
  assign palu_imm      = r_imm;
  assign palu_pw       = r_pw;
  assign palu_class    = r_class;
  assign palu_subclass = r_subclass;

  assign cpr_rd_ben    = w_wb ? r_wb_ben : 4'h0;
  assign cpr_rd_addr   = r_crd;
  assign cpr_rd_wdata  = r_wb_data;

  assign busy          = (r_state != ST_IDLE);
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_palu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_scarv_cop_palu_issue                                |
// | Description : Directed self-checking bench for the packed-ALU issue  |
// |               stage: reset, single op, cmov, back-to-back forward,   |
// |               timeout, flush, stray done, mid-EXEC reset.            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_scarv_cop_palu_issue;

  logic        g_clk;
  logic        g_resetn;
  logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr;
  logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata;
  logic        palu_ivalid, palu_idone;
  logic [31:0] palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3, palu_imm;
  logic [2:0]  palu_pw;
  logic [3:0]  palu_class;
  logic [4:0]  palu_subclass;
  logic [3:0]  palu_cpr_rd_ben;
  logic [31:0] palu_cpr_rd_wdata;
  logic [3:0]  cpr_rd_ben, cpr_rd_addr;
  logic [31:0] cpr_rd_wdata;
  logic        flush, busy, timeout_err;

  logic [31:0] rf [16];
  int vectors;
  int miscompares;
  int wr_count;
  int w0;

  scarv_cop_palu_issue_if id_if ();

  scarv_cop_palu_issue #(.TIMEOUT_CYCLES(64)) dut (
    .g_clk (g_clk), .g_resetn (g_resetn), .id (id_if),
    .cpr_rs1_addr (cpr_rs1_addr), .cpr_rs1_rdata (cpr_rs1_rdata),
    .cpr_rs2_addr (cpr_rs2_addr), .cpr_rs2_rdata (cpr_rs2_rdata),
    .cpr_rs3_addr (cpr_rs3_addr), .cpr_rs3_rdata (cpr_rs3_rdata),
    .palu_ivalid (palu_ivalid), .palu_idone (palu_idone),
    .palu_gpr_rs1 (palu_gpr_rs1), .palu_rs1 (palu_rs1), .palu_rs2 (palu_rs2),
    .palu_rs3 (palu_rs3), .palu_imm (palu_imm), .palu_pw (palu_pw),
    .palu_class (palu_class), .palu_subclass (palu_subclass),
    .palu_cpr_rd_ben (palu_cpr_rd_ben), .palu_cpr_rd_wdata (palu_cpr_rd_wdata),
    .cpr_rd_ben (cpr_rd_ben), .cpr_rd_addr (cpr_rd_addr), .cpr_rd_wdata (cpr_rd_wdata),
    .flush (flush), .busy (busy), .timeout_err (timeout_err)
  );

  // Register-file model behind the combinational read ports.
  assign cpr_rs1_rdata = rf[cpr_rs1_addr];
  assign cpr_rs2_rdata = rf[cpr_rs2_addr];
  assign cpr_rs3_rdata = rf[cpr_rs3_addr];

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Every cycle with a non-zero byte enable is a CPR write.
  always @(negedge g_clk) if (cpr_rd_ben !== 4'h0) wr_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                       input logic [3:0] crd, input logic [31:0] imm, input logic [31:0] gpr);
    id_if.id_class    = 4'd1;
    id_if.id_subclass = 5'd1;
    id_if.id_pw       = 3'd0;
    id_if.id_crs1     = c1;
    id_if.id_crs2     = c2;
    id_if.id_crs3     = c3;
    id_if.id_crd      = crd;
    id_if.id_imm      = imm;
    id_if.id_gpr_rs1  = gpr;
    id_if.id_valid    = 1'b1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    id_if.id_valid = 1'b0; id_if.id_class = 4'h0; id_if.id_subclass = 5'h0; id_if.id_pw = 3'h0;
    id_if.id_imm = 32'h0; id_if.id_crs1 = 4'h0; id_if.id_crs2 = 4'h0; id_if.id_crs3 = 4'h0;
    id_if.id_crd = 4'h0; id_if.id_gpr_rs1 = 32'h0;
    palu_idone = 1'b0; palu_cpr_rd_ben = 4'h0; palu_cpr_rd_wdata = 32'h0; flush = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    step(); step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    vectors++; if (palu_ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_ivalid got=%0h exp=0", palu_ivalid); end
    vectors++; if (cpr_rd_ben !== 4'h0) begin miscompares++; $display("FAIL reset_ben got=%0h exp=0", cpr_rd_ben); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%0h exp=0", timeout_err); end
    vectors++; if (palu_rs1 !== 32'h0 || palu_imm !== 32'h0 || cpr_rd_addr !== 4'h0) begin miscompares++; $display("FAIL reset_fields got=%0h/%0h/%0h exp=0", palu_rs1, palu_imm, cpr_rd_addr); end
    g_resetn = 1'b1;
    step();
    vectors++; if (id_if.id_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%0h exp=1", id_if.id_ready); end
  endtask

  task automatic test_padd();
    rf[4] = 32'h00000005; rf[5] = 32'h00000003; rf[6] = 32'h00000077;
    issue(4'd4, 4'd5, 4'd6, 4'd2, 32'h000000AA, 32'hCAFE0001);
    #1;
    vectors++; if (cpr_rs1_addr !== 4'd4 || cpr_rs2_addr !== 4'd5 || cpr_rs3_addr !== 4'd6) begin miscompares++; $display("FAIL padd_rdaddr got=%0h/%0h/%0h exp=4/5/6", cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr); end
    step();
    id_if.id_valid = 1'b0;
    vectors++; if (palu_ivalid !== 1'b1 || id_if.id_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL padd_exec got=%0h%0h%0h exp=101", palu_ivalid, id_if.id_ready, busy); end
    vectors++; if (palu_rs1 !== 32'h5 || palu_rs2 !== 32'h3 || palu_rs3 !== 32'h77) begin miscompares++; $display("FAIL padd_ops got=%0h/%0h/%0h exp=5/3/77", palu_rs1, palu_rs2, palu_rs3); end
    vectors++; if (palu_imm !== 32'hAA || palu_gpr_rs1 !== 32'hCAFE0001 || palu_class !== 4'd1 || palu_subclass !== 5'd1 || palu_pw !== 3'd0) begin miscompares++; $display("FAIL padd_fields got=%0h/%0h/%0h/%0h exp=aa/cafe0001/1/1", palu_imm, palu_gpr_rs1, palu_class, palu_subclass); end
    vectors++; if (cpr_rd_ben !== 4'h0) begin miscompares++; $display("FAIL padd_exec_ben got=%0h exp=0", cpr_rd_ben); end
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h00000008;
    step();
    palu_idone = 1'b0;
    vectors++; if (cpr_rd_ben !== 4'hF || cpr_rd_addr !== 4'd2 || cpr_rd_wdata !== 32'h8) begin miscompares++; $display("FAIL padd_wb got=%0h/%0h/%0h exp=f/2/8", cpr_rd_ben, cpr_rd_addr, cpr_rd_wdata); end
    vectors++; if (palu_ivalid !== 1'b0 || id_if.id_ready !== 1'b1) begin miscompares++; $display("FAIL padd_wb_hs got=%0h%0h exp=01", palu_ivalid, id_if.id_ready); end
    step();
    vectors++; if (cpr_rd_ben !== 4'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL padd_idle got=%0h/%0h exp=0/0", cpr_rd_ben, busy); end
  endtask

  task automatic test_cmov();
    w0 = wr_count;
    rf[2] = 32'h12345678; rf[7] = 32'h0;
    issue(4'd8, 4'd7, 4'd9, 4'd2, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'h0; palu_cpr_rd_wdata = 32'hDEADBEEF;
    step();
    palu_idone = 1'b0;
    vectors++; if (cpr_rd_ben !== 4'h0 || busy !== 1'b1) begin miscompares++; $display("FAIL cmov_wb_ben got=%0h/%0h exp=0/1", cpr_rd_ben, busy); end
    issue(4'd2, 4'd10, 4'd11, 4'd5, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    vectors++; if (palu_ivalid !== 1'b1 || palu_rs1 !== 32'h12345678) begin miscompares++; $display("FAIL cmov_nofwd got=%0h/%0h exp=1/12345678", palu_ivalid, palu_rs1); end
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'h1; palu_cpr_rd_wdata = 32'h0;
    step();
    palu_idone = 1'b0;
    step();
    vectors++; if (wr_count - w0 !== 1) begin miscompares++; $display("FAIL cmov_writes got=%0d exp=1", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    rf[3] = 32'h11223344; rf[12] = 32'h00000055;
    issue(4'd1, 4'd2, 4'd12, 4'd3, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'h3; palu_cpr_rd_wdata = 32'hAABBCCDD;
    step();
    palu_idone = 1'b0;
    vectors++; if (cpr_rd_ben !== 4'h3 || cpr_rd_addr !== 4'd3 || cpr_rd_wdata !== 32'hAABBCCDD) begin miscompares++; $display("FAIL b2b_wb got=%0h/%0h/%0h exp=3/3/aabbccdd", cpr_rd_ben, cpr_rd_addr, cpr_rd_wdata); end
    issue(4'd3, 4'd3, 4'd12, 4'd4, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    vectors++; if (palu_ivalid !== 1'b1) begin miscompares++; $display("FAIL b2b_exec got=%0h exp=1", palu_ivalid); end
    vectors++; if (palu_rs1 !== 32'h1122CCDD || palu_rs2 !== 32'h1122CCDD) begin miscompares++; $display("FAIL b2b_fwd got=%0h/%0h exp=1122ccdd", palu_rs1, palu_rs2); end
    vectors++; if (palu_rs3 !== 32'h55) begin miscompares++; $display("FAIL b2b_nofwd got=%0h exp=55", palu_rs3); end
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h1;
    step();
    palu_idone = 1'b0;
    vectors++; if (cpr_rd_ben !== 4'hF || cpr_rd_addr !== 4'd4) begin miscompares++; $display("FAIL b2b_wb2 got=%0h/%0h exp=f/4", cpr_rd_ben, cpr_rd_addr); end
    step();
  endtask

  task automatic test_timeout();
    w0 = wr_count;
    rf[1] = 32'h01010101;
    issue(4'd1, 4'd2, 4'd3, 4'd6, 32'h0, 32'h0);
    step();
    // Keep offering a different instruction; it must neither be taken nor disturb the held fields.
    issue(4'd0, 4'd0, 4'd0, 4'd9, 32'h5, 32'h5);
    for (int i = 0; i < 63; i++) begin
      step();
      vectors++; if (palu_ivalid !== 1'b1 || palu_rs1 !== 32'h01010101 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_hold[%0d] got=%0h/%0h/%0h exp=1/01010101/0", i, palu_ivalid, palu_rs1, timeout_err); end
    end
    id_if.id_valid = 1'b0;
    step();
    vectors++; if (timeout_err !== 1'b1 || busy !== 1'b0 || id_if.id_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_pulse got=%0h/%0h/%0h exp=1/0/1", timeout_err, busy, id_if.id_ready); end
    step();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse_end got=%0h exp=0", timeout_err); end
    vectors++; if (wr_count - w0 !== 0) begin miscompares++; $display("FAIL tmo_writes got=%0d exp=0", wr_count - w0); end
    issue(4'd1, 4'd2, 4'd3, 4'd7, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    repeat (63) step();
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h00000064;
    step();
    palu_idone = 1'b0;
    vectors++; if (cpr_rd_ben !== 4'hF || cpr_rd_wdata !== 32'h64 || cpr_rd_addr !== 4'd7 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_race got=%0h/%0h/%0h/%0h exp=f/64/7/0", cpr_rd_ben, cpr_rd_wdata, cpr_rd_addr, timeout_err); end
    step();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_race_err got=%0h exp=0", timeout_err); end
  endtask

  task automatic test_flush();
    w0 = wr_count;
    issue(4'd1, 4'd2, 4'd3, 4'd8, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    flush = 1'b1; palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h99;
    step();
    flush = 1'b0; palu_idone = 1'b0;
    vectors++; if (busy !== 1'b0 || palu_ivalid !== 1'b0 || cpr_rd_ben !== 4'h0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL flush_exec got=%0h/%0h/%0h/%0h exp=0/0/0/0", busy, palu_ivalid, cpr_rd_ben, timeout_err); end
    step();
    vectors++; if (wr_count - w0 !== 0) begin miscompares++; $display("FAIL flush_writes got=%0d exp=0", wr_count - w0); end
    issue(4'd1, 4'd2, 4'd3, 4'd9, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'h5; palu_cpr_rd_wdata = 32'h12;
    step();
    palu_idone = 1'b0;
    flush = 1'b1;
    issue(4'd1, 4'd2, 4'd3, 4'd10, 32'h0, 32'h0);
    #1;
    vectors++; if (id_if.id_ready !== 1'b0 || cpr_rd_ben !== 4'h5 || cpr_rd_addr !== 4'd9) begin miscompares++; $display("FAIL flush_wb got=%0h/%0h/%0h exp=0/5/9", id_if.id_ready, cpr_rd_ben, cpr_rd_addr); end
    step();
    vectors++; if (busy !== 1'b0 || id_if.id_ready !== 1'b0) begin miscompares++; $display("FAIL flush_wb_notake got=%0h/%0h exp=0/0", busy, id_if.id_ready); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle got=%0h exp=0", busy); end
    id_if.id_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_idone_outside();
    w0 = wr_count;
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h33;
    step(); step();
    palu_idone = 1'b0;
    vectors++; if (busy !== 1'b0 || cpr_rd_ben !== 4'h0 || wr_count - w0 !== 0) begin miscompares++; $display("FAIL stray_done got=%0h/%0h/%0d exp=0/0/0", busy, cpr_rd_ben, wr_count - w0); end
  endtask

  task automatic test_reset_exec();
    w0 = wr_count;
    issue(4'd1, 4'd2, 4'd3, 4'd11, 32'h0, 32'h0);
    step();
    id_if.id_valid = 1'b0;
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h44;
    g_resetn = 1'b0;
    #1;
    vectors++; if (palu_ivalid !== 1'b0 || busy !== 1'b0 || cpr_rd_ben !== 4'h0) begin miscompares++; $display("FAIL rst_exec got=%0h/%0h/%0h exp=0/0/0", palu_ivalid, busy, cpr_rd_ben); end
    step();
    g_resetn = 1'b1;
    step(); step();
    palu_idone = 1'b0;
    vectors++; if (busy !== 1'b0 || id_if.id_ready !== 1'b1 || wr_count - w0 !== 0) begin miscompares++; $display("FAIL rst_exec_after got=%0h/%0h/%0d exp=0/1/0", busy, id_if.id_ready, wr_count - w0); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    wr_count = 0;
    test_reset();
    test_padd();
    test_cmov();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_idone_outside();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
